// File: rtl/kdtree_load_ctrl_pkg.sv
// Shared constants, load FSM state encoding and patch type for the kd-tree load controller.
package kdtree_pkg;

   localparam int DATA_WIDTH = 11;
   localparam int PATCH_SIZE = 5;
   localparam int LEAF_SIZE  = 8;
   localparam int NUM_LEAVES = 64;
   localparam int NUM_NODES  = NUM_LEAVES - 1;
   localparam int NUM_QUERYS = 494;

   localparam int NODE_AW  = $clog2(NUM_NODES);
   localparam int DIM_W    = $clog2(PATCH_SIZE);
   localparam int LEAF_AW  = $clog2(NUM_LEAVES);
   localparam int SLOT_W   = $clog2(LEAF_SIZE);
   localparam int QUERY_AW = $clog2(NUM_QUERYS);
   localparam int ELEM_W   = $clog2(PATCH_SIZE);

   localparam logic [NODE_AW-1:0]  LAST_NODE  = NODE_AW'(NUM_NODES - 1);
   localparam logic [LEAF_AW-1:0]  LAST_LEAF  = LEAF_AW'(NUM_LEAVES - 1);
   localparam logic [SLOT_W-1:0]   LAST_SLOT  = SLOT_W'(LEAF_SIZE - 1);
   localparam logic [QUERY_AW-1:0] LAST_QUERY = QUERY_AW'(NUM_QUERYS - 1);
   localparam logic [ELEM_W-1:0]   LAST_ELEM  = ELEM_W'(PATCH_SIZE - 1);

   typedef enum logic [2:0] {
      IDLE,
      NODES,
      LEAVES,
      QUERIES,
      DONE
   } load_state_e;

   typedef logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0] patch_t;

endpackage

// File: rtl/kdtree_load_ctrl_if.sv
// FIFO read side and node/leaf/query write ports of the kd-tree load controller.
interface kdtree_load_ctrl_if;
   import kdtree_pkg::*;

   logic                  fifo_rempty_n;
   logic [DATA_WIDTH-1:0] fifo_rdata;
   logic                  fifo_deq;

   logic                  node_wen;
   logic [NODE_AW-1:0]    node_waddr;
   logic [DIM_W-1:0]      node_wdim;
   logic [DATA_WIDTH-1:0] node_wmedian;

   logic                  leaf_wen;
   logic [LEAF_AW-1:0]    leaf_waddr;
   logic [SLOT_W-1:0]     leaf_wslot;
   patch_t                leaf_wdata;
   logic [DATA_WIDTH-1:0] leaf_wpidx;

   logic                  query_wen;
   logic [QUERY_AW-1:0]   query_waddr;
   patch_t                query_wdata;

   logic                  busy;
   logic                  load_done;

   modport master (
      input  fifo_rempty_n, fifo_rdata,
      output fifo_deq,
      output node_wen, node_waddr, node_wdim, node_wmedian,
      output leaf_wen, leaf_waddr, leaf_wslot, leaf_wdata, leaf_wpidx,
      output query_wen, query_waddr, query_wdata,
      output busy, load_done
   );

   modport slave (
      output fifo_rempty_n, fifo_rdata,
      input  fifo_deq,
      input  node_wen, node_waddr, node_wdim, node_wmedian,
      input  leaf_wen, leaf_waddr, leaf_wslot, leaf_wdata, leaf_wpidx,
      input  query_wen, query_waddr, query_wdata,
      input  busy, load_done
   );

endinterface

// File: rtl/kdtree_load_ctrl_patch_assembler.sv
// Shifts FIFO words into a patch, element 0 ending in the LSBs; done marks the word completing a patch.
module patch_assembler
   import kdtree_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] word,
   output patch_t                patch,
   output patch_t                patch_next,
   output logic                  done
);

   logic [ELEM_W-1:0] elem_q;

   assign patch_next = {word, patch[PATCH_SIZE-1:1]};
   assign done       = shift_en && (elem_q == LAST_ELEM);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         patch  <= '0;
         elem_q <= '0;
      end else if (clear) begin
         patch  <= '0;
         elem_q <= '0;
      end else if (shift_en) begin
         patch  <= patch_next;
         elem_q <= done ? '0 : elem_q + 1'b1;
      end
   end

endmodule

// File: rtl/kdtree_load_ctrl.sv
// Streams FIFO words into kd-tree node, leaf and query memories after load_kdtree.
// Optional KDTREE_LOAD_QUERY_RELOAD_EN adds load_query to reload only the query memory.
module kdtree_load_ctrl
   import kdtree_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic load_kdtree,
`ifdef KDTREE_LOAD_QUERY_RELOAD_EN
   input  logic load_query,
`endif
   kdtree_load_ctrl_if.master bus
);

   load_state_e state_q, state_d;

   logic                  deq;
   logic [NODE_AW-1:0]    node_cnt_q;
   logic                  node_odd_q;
   logic [DIM_W-1:0]      dim_q;
   logic [LEAF_AW-1:0]    leaf_cnt_q;
   logic [SLOT_W-1:0]     slot_q;
   logic                  pidx_phase_q;
   logic [QUERY_AW-1:0]   query_cnt_q;

   logic   asm_shift, asm_done;
   patch_t asm_patch, asm_patch_next;

   logic node_last_word, leaf_last_word, query_last_word;
   logic nodes_end, leaves_end, queries_end;

   assign deq          = bus.fifo_rempty_n &&
                         (state_q inside {NODES, LEAVES, QUERIES});
   assign bus.fifo_deq = deq;
   assign bus.busy     = (state_q != IDLE);

   assign asm_shift = deq && ((state_q == LEAVES && !pidx_phase_q) || state_q == QUERIES);

   assign node_last_word  = deq && (state_q == NODES) && node_odd_q;
   assign leaf_last_word  = deq && (state_q == LEAVES) && pidx_phase_q;
   assign query_last_word = (state_q == QUERIES) && asm_done;

   assign nodes_end   = node_last_word && (node_cnt_q == LAST_NODE);
   assign leaves_end  = leaf_last_word && (leaf_cnt_q == LAST_LEAF) && (slot_q == LAST_SLOT);
   assign queries_end = query_last_word && (query_cnt_q == LAST_QUERY);

   patch_assembler u_patch_assembler (
      .clk        (clk),
      .rst        (rst),
      .clear      (state_q == IDLE),
      .shift_en   (asm_shift),
      .word       (bus.fifo_rdata),
      .patch      (asm_patch),
      .patch_next (asm_patch_next),
      .done       (asm_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // NOTE: state_d is assigned before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (load_kdtree) state_d = NODES;
`ifdef KDTREE_LOAD_QUERY_RELOAD_EN
            else if (load_query) state_d = QUERIES;
`endif
         end
         NODES:   if (nodes_end)   state_d = LEAVES;
         LEAVES:  if (leaves_end)  state_d = QUERIES;
         QUERIES: if (queries_end) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Write ports default to zero every cycle so addr/data are only non-zero with their strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         node_cnt_q       <= '0;
         node_odd_q       <= 1'b0;
         dim_q            <= '0;
         leaf_cnt_q       <= '0;
         slot_q           <= '0;
         pidx_phase_q     <= 1'b0;
         query_cnt_q      <= '0;
         bus.node_wen     <= 1'b0;
         bus.node_waddr   <= '0;
         bus.node_wdim    <= '0;
         bus.node_wmedian <= '0;
         bus.leaf_wen     <= 1'b0;
         bus.leaf_waddr   <= '0;
         bus.leaf_wslot   <= '0;
         bus.leaf_wdata   <= '0;
         bus.leaf_wpidx   <= '0;
         bus.query_wen    <= 1'b0;
         bus.query_waddr  <= '0;
         bus.query_wdata  <= '0;
         bus.load_done    <= 1'b0;
      end else begin
         bus.node_wen     <= 1'b0;
         bus.node_waddr   <= '0;
         bus.node_wdim    <= '0;
         bus.node_wmedian <= '0;
         bus.leaf_wen     <= 1'b0;
         bus.leaf_waddr   <= '0;
         bus.leaf_wslot   <= '0;
         bus.leaf_wdata   <= '0;
         bus.leaf_wpidx   <= '0;
         bus.query_wen    <= 1'b0;
         bus.query_waddr  <= '0;
         bus.query_wdata  <= '0;
         bus.load_done    <= (state_q == DONE);

         if (state_q == IDLE) begin
            node_cnt_q   <= '0;
            node_odd_q   <= 1'b0;
            dim_q        <= '0;
            leaf_cnt_q   <= '0;
            slot_q       <= '0;
            pidx_phase_q <= 1'b0;
            query_cnt_q  <= '0;
         end

         if (deq && state_q == NODES) begin
            if (!node_odd_q) begin
               dim_q      <= bus.fifo_rdata[DIM_W-1:0];
               node_odd_q <= 1'b1;
            end else begin
               bus.node_wen     <= 1'b1;
               bus.node_waddr   <= node_cnt_q;
               bus.node_wdim    <= dim_q;
               bus.node_wmedian <= bus.fifo_rdata;
               node_odd_q       <= 1'b0;
               if (node_cnt_q != LAST_NODE) node_cnt_q <= node_cnt_q + 1'b1;
            end
         end

         if (deq && state_q == LEAVES) begin
            if (!pidx_phase_q) begin
               if (asm_done) pidx_phase_q <= 1'b1;
            end else begin
               bus.leaf_wen   <= 1'b1;
               bus.leaf_waddr <= leaf_cnt_q;
               bus.leaf_wslot <= slot_q;
               bus.leaf_wdata <= asm_patch;
               bus.leaf_wpidx <= bus.fifo_rdata;
               pidx_phase_q   <= 1'b0;
               if (slot_q == LAST_SLOT) begin
                  slot_q <= '0;
                  if (leaf_cnt_q != LAST_LEAF) leaf_cnt_q <= leaf_cnt_q + 1'b1;
               end else begin
                  slot_q <= slot_q + 1'b1;
               end
            end
         end

         // The query's final element is still on the FIFO head, so take the assembler's next value.
         if (query_last_word) begin
            bus.query_wen   <= 1'b1;
            bus.query_waddr <= query_cnt_q;
            bus.query_wdata <= asm_patch_next;
            if (query_cnt_q != LAST_QUERY) query_cnt_q <= query_cnt_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_kdtree_load_ctrl.sv
// Scoreboard bench for kdtree_load_ctrl; define KDTREE_LOAD_QUERY_RELOAD_EN to cover load_query.
module tb_kdtree_load_ctrl;
   import kdtree_pkg::*;

   logic clk;
   logic rst;
   logic load_kdtree;
`ifdef KDTREE_LOAD_QUERY_RELOAD_EN
   logic load_query;
`endif

   kdtree_load_ctrl_if bus();

   kdtree_load_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .load_kdtree (load_kdtree),
`ifdef KDTREE_LOAD_QUERY_RELOAD_EN
      .load_query  (load_query),
`endif
      .bus         (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [79:0] node_q[$];
   logic [79:0] leaf_q[$];
   logic [79:0] query_q[$];

   int cnt_node = 0, cnt_leaf = 0, cnt_query = 0, cnt_done = 0, deq_viol = 0;
   int snap_node, snap_leaf, snap_query, snap_done, snap_viol;
   bit prev_qlast = 1'b0;

   task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_WIDTH-1:0] node_dim(int i);
      return (i == 0) ? 11'd3 : 11'(i % 5);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] node_med(int i);
      return (i == 0) ? 11'd412 : 11'((i * 29 + 5) % 2048);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] leaf_elem(int l, int s, int j);
      if (l == 0 && s == 7) return 11'(j + 1);
      return 11'((l * 97 + s * 13 + j * 5 + 1) % 2048);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] leaf_pidx(int l, int s);
      return (l == 0 && s == 7) ? 11'd77 : 11'((l * 8 + s + 600) % 2048);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] query_elem(int q, int j);
      return 11'((q * 5 + j + 300) % 2048);
   endfunction

   // Present one word; an optional empty cycle precedes it.
   task automatic send(input logic [DATA_WIDTH-1:0] w, input bit gap);
      if (gap) begin
         bus.fifo_rempty_n = 1'b0;
         @(negedge clk);
         check("deq_gap", 80'(bus.fifo_deq), 80'd0);
         @(posedge clk); #1;
      end
      bus.fifo_rempty_n = 1'b1;
      bus.fifo_rdata    = w;
      @(negedge clk);
      check("deq", 80'(bus.fifo_deq), 80'd1);
      @(posedge clk); #1;
      bus.fifo_rempty_n = 1'b0;
   endtask

   task automatic snapshot();
      snap_node  = cnt_node;
      snap_leaf  = cnt_leaf;
      snap_query = cnt_query;
      snap_done  = cnt_done;
      snap_viol  = deq_viol;
   endtask

   task automatic start_load();
      load_kdtree = 1'b1;
      @(posedge clk); #1;
      load_kdtree = 1'b0;
      @(negedge clk);
      check("busy_start", 80'(bus.busy), 80'd1);
      @(posedge clk); #1;
   endtask

   // Node words then leaf words; leaf_word_limit < 0 sends the complete leaf section.
   task automatic load_tree(input int leaf_word_limit, input bit poke_busy);
      int sent = 0;
      for (int i = 0; i < NUM_NODES; i++) begin
         if (poke_busy && i == 10) load_kdtree = 1'b1;
         send(node_dim(i), 1'b0);
         load_kdtree = 1'b0;
         send(node_med(i), 1'b0);
         node_q.push_back(80'({6'(i), node_dim(i)[2:0], node_med(i)}));
      end
      for (int l = 0; l < NUM_LEAVES; l++) begin
         for (int s = 0; s < LEAF_SIZE; s++) begin
            patch_t p;
            for (int j = 0; j < PATCH_SIZE; j++) begin
               if (leaf_word_limit >= 0 && sent == leaf_word_limit) return;
               p[j] = leaf_elem(l, s, j);
               send(p[j], 1'b0);
               sent++;
            end
            if (leaf_word_limit >= 0 && sent == leaf_word_limit) return;
            send(leaf_pidx(l, s), 1'b0);
            sent++;
            leaf_q.push_back(80'({6'(l), 3'(s), p, leaf_pidx(l, s)}));
         end
      end
   endtask

   task automatic load_queries(input bit gaps);
      for (int q = 0; q < NUM_QUERYS; q++) begin
         patch_t p;
         for (int j = 0; j < PATCH_SIZE; j++) begin
            p[j] = query_elem(q, j);
            send(p[j], gaps);
         end
         query_q.push_back(80'({9'(q), p}));
      end
   endtask

   // Runs in the DONE cycle: a start pulse and a non-empty FIFO must both be ignored there.
   task automatic finish_load(input int exp_nodes, input int exp_leaves);
      load_kdtree       = 1'b1;
      bus.fifo_rempty_n = 1'b1;
      @(negedge clk);
      check("deq_in_done", 80'(bus.fifo_deq), 80'd0);
      check("busy_in_done", 80'(bus.busy), 80'd1);
      @(posedge clk); #1;
      load_kdtree       = 1'b0;
      bus.fifo_rempty_n = 1'b0;
      @(negedge clk);
      check("busy_after_done", 80'(bus.busy), 80'd0);
      repeat (3) @(posedge clk);
      #1;
      check("node_count", 80'(cnt_node - snap_node), 80'(exp_nodes));
      check("leaf_count", 80'(cnt_leaf - snap_leaf), 80'(exp_leaves));
      check("query_count", 80'(cnt_query - snap_query), 80'(NUM_QUERYS));
      check("done_count", 80'(cnt_done - snap_done), 80'd1);
      check("deq_when_empty", 80'(deq_viol - snap_viol), 80'd0);
      check("queues_drained", 80'(node_q.size() + leaf_q.size() + query_q.size()), 80'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_strobes"}, 80'({bus.node_wen, bus.leaf_wen, bus.query_wen}), 80'd0);
      check({tag, "_busy_done"}, 80'({bus.busy, bus.load_done}), 80'd0);
      check({tag, "_deq"}, 80'(bus.fifo_deq), 80'd0);
      check({tag, "_addr"}, 80'({bus.node_waddr, bus.leaf_waddr, bus.leaf_wslot, bus.query_waddr}), 80'd0);
   endtask

   initial begin
      rst               = 1'b1;
      load_kdtree       = 1'b0;
`ifdef KDTREE_LOAD_QUERY_RELOAD_EN
      load_query        = 1'b0;
`endif
      bus.fifo_rempty_n = 1'b1;
      bus.fifo_rdata    = '0;

      fork
         forever begin
            @(negedge clk);
            if (bus.fifo_deq && !bus.fifo_rempty_n) deq_viol++;
            if (prev_qlast) check("load_done_after_last", 80'(bus.load_done), 80'd1);
            if (bus.load_done) begin
               cnt_done++;
               check("load_done_timing", 80'(prev_qlast), 80'd1);
            end
            if (bus.node_wen) begin
               cnt_node++;
               check("node_expected", 80'(node_q.size() != 0), 80'd1);
               if (node_q.size() != 0)
                  check("node_write", 80'({bus.node_waddr, bus.node_wdim, bus.node_wmedian}),
                        node_q.pop_front());
            end
            if (bus.leaf_wen) begin
               cnt_leaf++;
               check("leaf_expected", 80'(leaf_q.size() != 0), 80'd1);
               if (leaf_q.size() != 0)
                  check("leaf_write", 80'({bus.leaf_waddr, bus.leaf_wslot, bus.leaf_wdata, bus.leaf_wpidx}),
                        leaf_q.pop_front());
            end
            if (bus.query_wen) begin
               cnt_query++;
               check("query_expected", 80'(query_q.size() != 0), 80'd1);
               if (query_q.size() != 0)
                  check("query_write", 80'({bus.query_waddr, bus.query_wdata}), query_q.pop_front());
            end
            prev_qlast = bus.query_wen && (bus.query_waddr == LAST_QUERY);
         end
      join_none

      // Reset state, with a non-empty FIFO that must not be popped.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst               = 1'b0;
      bus.fifo_rempty_n = 1'b0;
      @(posedge clk); #1;

      // Full load, FIFO never empty, with a stray start pulse while busy.
      snapshot();
      start_load();
      load_tree(-1, 1'b1);
      load_queries(1'b0);
      finish_load(NUM_NODES, NUM_LEAVES * LEAF_SIZE);

      // Reset after 200 leaf words: everything drops at once.
      start_load();
      load_tree(200, 1'b0);
      rst               = 1'b1;
      bus.fifo_rempty_n = 1'b1;
      @(negedge clk);
      check_idle_outputs("mid_rst");
      check("mid_rst_queues", 80'(node_q.size() + leaf_q.size()), 80'd0);
      @(posedge clk); #1;
      rst               = 1'b0;
      bus.fifo_rempty_n = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_rst");
      @(posedge clk); #1;

      // Fresh load restarts at node 0; FIFO alternates empty/non-empty through queries.
      snapshot();
      start_load();
      load_tree(-1, 1'b0);
      load_queries(1'b1);
      finish_load(NUM_NODES, NUM_LEAVES * LEAF_SIZE);

`ifdef KDTREE_LOAD_QUERY_RELOAD_EN
      // Query-only reload leaves the tree memories untouched.
      snapshot();
      load_query = 1'b1;
      @(posedge clk); #1;
      load_query = 1'b0;
      @(negedge clk);
      check("busy_reload", 80'(bus.busy), 80'd1);
      @(posedge clk); #1;
      load_queries(1'b0);
      finish_load(0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
